// File: rtl/sc_fetch_unit.sv
// ----------------------------------------------------------------------------
// sc_fetch_unit
// Instruction-fetch stage feeding the single-cycle control unit. It holds the
// PC, fetches one word per instruction over a req/ready handshake (any number
// of wait states), then presents the instruction and its op/func fields until
// the datapath commits. On commit the next PC is chosen from pcsource; a
// misaligned target parks the unit in a sticky FAULT state until reset.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr    fetch request (FETCH only) and its address (= pc)
//   imem_ready/imem_rdata memory response, sampled only in FETCH
//   commit, pcsource      retire current instruction and pick next PC
//                         (00 pc4, 01 bpc, 10 ra, 11 jpc)
//   bpc, jpc, ra          candidate targets, sampled only at the commit edge
//   inst, inst_valid      registered instruction, valid only in VALID
//   op, func              inst[31:26] and inst[5:0]
//   pc, pc4               address of inst and pc + 4 (mod 2^32)
//   fault                 sticky misaligned-target flag
//   retire_cnt            number of committed instructions, wraps
// ----------------------------------------------------------------------------
module sc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        commit,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fault,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] pc4_s;
    logic [31:0] npc_s;

    // Next-PC multiplexer keyed by the control unit's pcsource code.
    function automatic logic [31:0] select_npc(
        input logic [1:0]  src,
        input logic [31:0] seq_pc,
        input logic [31:0] br_pc,
        input logic [31:0] reg_pc,
        input logic [31:0] jmp_pc
    );
        logic [31:0] res;
        case (src)
            2'b00:   res = seq_pc;
            2'b01:   res = br_pc;
            2'b10:   res = reg_pc;
            2'b11:   res = jmp_pc;
            default: res = seq_pc;
        endcase
        return res;
    endfunction

    // Carry-out is intentionally dropped so 0xFFFF_FFFC wraps to 0.
    assign pc4_s = pc_q + 32'd4;
    assign npc_s = select_npc(pcsource, pc4_s, bpc, ra, jpc);

    // State register and datapath flops; async reset drops imem_req at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0000_0000;
            retire_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            retire_q <= retire_d;
        end
    end

    // Next-state and next-value logic; every input is ignored outside the
    // state that consumes it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        retire_d = retire_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (commit) begin
                    // The faulting instruction still counts as retired.
                    retire_d = retire_q + 32'd1;
                    if (npc_s[1:0] == 2'b00) begin
                        pc_d    = npc_s;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unreachable encoding: stop safely rather than fetch.
                state_d = ST_FAULT;
            end
        endcase
    end

    // Outputs decode straight from flops so they are glitch-free and reset
    // forces all handshake outputs low without waiting for a clock.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == ST_VALID);
    assign fault      = (state_q == ST_FAULT);
    assign inst       = inst_q;
    assign op         = inst_q[31:26];
    assign func       = inst_q[5:0];
    assign pc         = pc_q;
    assign pc4        = pc4_s;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_sc_fetch_unit.sv
module tb_sc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        commit;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  op, func;
    logic [31:0] pc, pc4;
    logic        fault;
    logic [31:0] retire_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_retire;

    sc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .commit(commit), .pcsource(pcsource),
        .bpc(bpc), .jpc(jpc), .ra(ra),
        .inst(inst), .inst_valid(inst_valid), .op(op), .func(func),
        .pc(pc), .pc4(pc4), .fault(fault), .retire_cnt(retire_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_1E77;
    endfunction

    // One instruction: wait for req, apply wait states, return data, commit.
    task automatic do_instr(input int waits, input logic [1:0] src,
                            input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
        logic [31:0] exp_a, w, npc;
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val("req", {31'd0, imem_req}, 32'd1);
        exp_a = exp_addr_q.pop_front();
        check_val("addr", imem_addr, exp_a);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            @(negedge clock);
            check_val("wait_req", {31'd0, imem_req}, 32'd1);
            check_val("wait_addr", imem_addr, exp_a);
            check_val("wait_valid", {31'd0, inst_valid}, 32'd0);
            check_val("wait_retire", retire_cnt, exp_retire);
        end
        w = mem_word(exp_a);
        imem_ready = 1'b1;
        imem_rdata = w;
        exp_inst_q.push_back(w);
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        w = exp_inst_q.pop_front();
        check_val("inst_valid", {31'd0, inst_valid}, 32'd1);
        check_val("inst", inst, w);
        check_val("op", {26'd0, op}, {26'd0, w[31:26]});
        check_val("func", {26'd0, func}, {26'd0, w[5:0]});
        check_val("pc", pc, exp_a);
        check_val("pc4", pc4, exp_a + 32'd4);
        case (src)
            2'b00:   npc = exp_a + 32'd4;
            2'b01:   npc = b;
            2'b10:   npc = r;
            default: npc = j;
        endcase
        pcsource = src; bpc = b; jpc = j; ra = r;
        commit = 1'b1;
        exp_retire = exp_retire + 32'd1;
        if (npc[1:0] == 2'b00) exp_addr_q.push_back(npc);
        @(negedge clock);
        // Targets are garbage after the commit edge; they must not matter.
        commit = 1'b0;
        pcsource = ~src; bpc = $urandom; jpc = $urandom; ra = $urandom;
        check_val("retire", retire_cnt, exp_retire);
        if (npc[1:0] == 2'b00) begin
            // Back-to-back: the next fetch is already requested.
            check_val("next_req", {31'd0, imem_req}, 32'd1);
            check_val("next_addr", imem_addr, npc);
        end else begin
            check_val("fault", {31'd0, fault}, 32'd1);
            check_val("fault_req", {31'd0, imem_req}, 32'd0);
            check_val("fault_pc", pc, exp_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        commit = 1'b1;
        pcsource = 2'b00;
        bpc = 32'd0; jpc = 32'd0; ra = 32'd0;
        exp_retire = 32'd0;
        repeat (2) @(negedge clock);
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_val("rst_fault", {31'd0, fault}, 32'd0);
        check_val("rst_pc", pc, RST_PC);
        check_val("rst_inst", inst, 32'd0);
        check_val("rst_retire", retire_cnt, 32'd0);
        commit = 1'b0;
        imem_ready = 1'b0;
        reset = 1'b0;
        exp_addr_q.push_back(RST_PC);
        check_val("idle_req", {31'd0, imem_req}, 32'd0);

        // Sequential zero-wait fetches, then wait states.
        for (int k = 0; k < 3; k++) do_instr(0, 2'b00, 32'd0, 32'd0, 32'd0);
        do_instr(3, 2'b00, 32'd0, 32'd0, 32'd0);
        // Branch, jump, jr, then the wrap-around at the top of memory.
        do_instr(0, 2'b01, 32'h0000_0200, 32'h0000_0444, 32'h0000_0888);
        do_instr(1, 2'b11, 32'h0000_0204, 32'h0000_0040, 32'h0000_0888);
        do_instr(0, 2'b10, 32'h0000_0204, 32'h0000_0444, 32'h0000_0080);
        do_instr(0, 2'b11, 32'd0, 32'hFFFF_FFFC, 32'd0);
        do_instr(0, 2'b00, 32'd0, 32'd0, 32'd0);
        do_instr(2, 2'b00, 32'd0, 32'd0, 32'd0);
        // Misaligned jr: sticky fault, commit and ready ignored afterwards.
        do_instr(0, 2'b10, 32'h0000_0300, 32'h0000_0300, 32'h0000_0082);
        commit = 1'b1;
        imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_val("hold_fault", {31'd0, fault}, 32'd1);
            check_val("hold_req", {31'd0, imem_req}, 32'd0);
            check_val("hold_valid", {31'd0, inst_valid}, 32'd0);
            check_val("hold_pc", pc, 32'h0000_0004);
            check_val("hold_retire", retire_cnt, exp_retire);
        end
        commit = 1'b0;
        imem_ready = 1'b0;

        // Reset out of FAULT, one instruction, then reset mid-wait.
        reset = 1'b1;
        #1;
        check_val("rst2_fault", {31'd0, fault}, 32'd0);
        exp_addr_q.delete();
        exp_addr_q.push_back(RST_PC);
        exp_retire = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        do_instr(0, 2'b00, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clock);
        check_val("midwait_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_req", {31'd0, imem_req}, 32'd0);
        check_val("async_pc", pc, RST_PC);
        check_val("async_retire", retire_cnt, 32'd0);
        exp_addr_q.delete();
        exp_addr_q.push_back(RST_PC);
        exp_retire = 32'd0;
        // Late ready for the abandoned fetch arrives around the restart.
        imem_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("late_idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
        check_val("late_valid", {31'd0, inst_valid}, 32'd0);
        do_instr(0, 2'b00, 32'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Hard time limit so a wedged DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
